// File: rtl/branch_predict_unit_pkg.sv
// Shared constants for the branch predict unit: condition codes,
// flag bit positions and 2-bit BHT counter states.
package branch_predict_unit_pkg;

    localparam logic [3:0] COND_EQ = 4'h0;
    localparam logic [3:0] COND_NE = 4'h1;
    localparam logic [3:0] COND_CS = 4'h2;
    localparam logic [3:0] COND_CC = 4'h3;
    localparam logic [3:0] COND_MI = 4'h4;
    localparam logic [3:0] COND_PL = 4'h5;
    localparam logic [3:0] COND_VS = 4'h6;
    localparam logic [3:0] COND_VC = 4'h7;
    localparam logic [3:0] COND_HI = 4'h8;
    localparam logic [3:0] COND_LS = 4'h9;
    localparam logic [3:0] COND_GE = 4'hA;
    localparam logic [3:0] COND_LT = 4'hB;
    localparam logic [3:0] COND_GT = 4'hC;
    localparam logic [3:0] COND_LE = 4'hD;
    localparam logic [3:0] COND_AL = 4'hE;
    localparam logic [3:0] COND_NV = 4'hF;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    localparam logic [1:0] BHT_SNT   = 2'b00;
    localparam logic [1:0] BHT_WNT   = 2'b01;
    localparam logic [1:0] BHT_WT    = 2'b10;
    localparam logic [1:0] BHT_ST    = 2'b11;
    localparam logic [1:0] BHT_RESET = BHT_WNT;

    // Saturating step of a 2-bit taken/not-taken counter.
    function automatic logic [1:0] bht_next(
        input logic [1:0] cnt,
        input logic       taken
    );
        logic [1:0] nxt;
        nxt = cnt;
        if (taken) begin
            if (cnt != BHT_ST)
                nxt = cnt + 2'd1;
        end else begin
            if (cnt != BHT_SNT)
                nxt = cnt - 2'd1;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/branch_predict_unit_if.sv
// Fetch-prediction and EX-resolution bundle for the branch predict unit.
// master = pipeline side, slave = predictor.
interface branch_predict_unit_if #(
    parameter int PC_WIDTH  = 32,
    parameter int CNT_WIDTH = 16
);
    logic [PC_WIDTH-1:0]  if_pc;
    logic                 if_pred_taken;
    logic                 ex_valid;
    logic                 ex_branch;
    logic [PC_WIDTH-1:0]  ex_pc;
    logic [3:0]           ex_cond;
    logic [3:0]           ex_flags;
    logic                 ex_pred_taken;
    logic                 res_valid;
    logic                 res_taken;
    logic                 mispredict;
    logic [CNT_WIDTH-1:0] branch_count;
    logic [CNT_WIDTH-1:0] mispred_count;

    modport master (
        output if_pc,
        output ex_valid,
        output ex_branch,
        output ex_pc,
        output ex_cond,
        output ex_flags,
        output ex_pred_taken,
        input  if_pred_taken,
        input  res_valid,
        input  res_taken,
        input  mispredict,
        input  branch_count,
        input  mispred_count
    );

    modport slave (
        input  if_pc,
        input  ex_valid,
        input  ex_branch,
        input  ex_pc,
        input  ex_cond,
        input  ex_flags,
        input  ex_pred_taken,
        output if_pred_taken,
        output res_valid,
        output res_taken,
        output mispredict,
        output branch_count,
        output mispred_count
    );

endinterface

// File: rtl/branch_predict_unit_cond_eval.sv
// Combinational condition-code evaluator: {N,Z,C,V} + cond -> taken.
// Also usable by predicated-execution logic.
module branch_predict_unit_cond_eval
    import branch_predict_unit_pkg::*;
(
    input  logic [3:0] i_cond,
    input  logic [3:0] i_flags,
    output logic       o_taken
);

    logic w_n;
    logic w_z;
    logic w_c;
    logic w_v;

    assign w_n = i_flags[FLAG_N];
    assign w_z = i_flags[FLAG_Z];
    assign w_c = i_flags[FLAG_C];
    assign w_v = i_flags[FLAG_V];

    always_comb begin
        o_taken = 1'b0;
        unique case (i_cond)
            COND_EQ: o_taken = w_z;
            COND_NE: o_taken = ~w_z;
            COND_CS: o_taken = w_c;
            COND_CC: o_taken = ~w_c;
            COND_MI: o_taken = w_n;
            COND_PL: o_taken = ~w_n;
            COND_VS: o_taken = w_v;
            COND_VC: o_taken = ~w_v;
            COND_HI: o_taken = w_c & ~w_z;
            COND_LS: o_taken = ~w_c | w_z;
            COND_GE: o_taken = (w_n == w_v);
            COND_LT: o_taken = (w_n != w_v);
            COND_GT: o_taken = ~w_z & (w_n == w_v);
            COND_LE: o_taken = w_z | (w_n != w_v);
            COND_AL: o_taken = 1'b1;
            COND_NV: o_taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/branch_predict_unit.sv
// Branch predictor: resolves EX branches, trains a 2-bit counter BHT
// and reports registered outcome, mispredict and statistics.
module branch_predict_unit
    import branch_predict_unit_pkg::*;
#(
    parameter int PC_WIDTH  = 32,
    parameter int BHT_DEPTH = 64,
    parameter int CNT_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    branch_predict_unit_if.slave  bpu
);

    localparam int IDX_W = $clog2(BHT_DEPTH);

    logic [1:0]           r_bht [BHT_DEPTH];
    logic                 r_res_valid;
    logic                 r_res_taken;
    logic                 r_mispredict;
    logic [CNT_WIDTH-1:0] r_branch_count;
    logic [CNT_WIDTH-1:0] r_mispred_count;

    logic [IDX_W-1:0]     w_if_idx;
    logic [IDX_W-1:0]     w_ex_idx;
    logic                 w_taken;
    logic                 w_resolve;
    logic                 w_miss;
    logic                 w_unused_pc;

    assign w_if_idx  = bpu.if_pc[IDX_W+1:2];
    assign w_ex_idx  = bpu.ex_pc[IDX_W+1:2];
    assign w_resolve = bpu.ex_valid & bpu.ex_branch;
    assign w_miss    = (w_taken != bpu.ex_pred_taken);

    // No tags: address bits outside the index only alias.
    assign w_unused_pc = ^{bpu.if_pc[PC_WIDTH-1:IDX_W+2],
                           bpu.if_pc[1:0],
                           bpu.ex_pc[PC_WIDTH-1:IDX_W+2],
                           bpu.ex_pc[1:0]};

    branch_predict_unit_cond_eval u_cond_eval (
        .i_cond  (bpu.ex_cond),
        .i_flags (bpu.ex_flags),
        .o_taken (w_taken)
    );

    // Read before write: a same-cycle update shows up next cycle.
    assign bpu.if_pred_taken = r_bht[w_if_idx][1];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < BHT_DEPTH; i++)
                r_bht[i] <= BHT_RESET;
            r_res_valid     <= 1'b0;
            r_res_taken     <= 1'b0;
            r_mispredict    <= 1'b0;
            r_branch_count  <= '0;
            r_mispred_count <= '0;
        end else begin
            r_res_valid  <= w_resolve;
            r_res_taken  <= w_resolve & w_taken;
            r_mispredict <= w_resolve & w_miss;
            if (w_resolve) begin
                r_bht[w_ex_idx] <= bht_next(r_bht[w_ex_idx], w_taken);
                if (~&r_branch_count)
                    r_branch_count <= r_branch_count + 1'b1;
                if (w_miss && ~&r_mispred_count)
                    r_mispred_count <= r_mispred_count + 1'b1;
            end
        end
    end

    assign bpu.res_valid     = r_res_valid;
    assign bpu.res_taken     = r_res_taken;
    assign bpu.mispredict    = r_mispredict;
    assign bpu.branch_count  = r_branch_count;
    assign bpu.mispred_count = r_mispred_count;

endmodule

// File: tb/tb_branch_predict_unit.sv
// Randomized bench for branch_predict_unit against a behavioural model;
// a second instance with 4-bit stats exercises counter saturation.
module tb_branch_predict_unit;

    localparam int PW    = 32;
    localparam int DEPTH = 64;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic [31:0] t_if_pc;
    logic [31:0] t_ex_pc;
    logic        t_valid;
    logic        t_branch;
    logic [3:0]  t_cond;
    logic [3:0]  t_flags;
    logic        t_pred;

    branch_predict_unit_if #(.PC_WIDTH(PW), .CNT_WIDTH(16)) bus16 ();
    branch_predict_unit_if #(.PC_WIDTH(PW), .CNT_WIDTH(4))  bus4 ();

    assign bus16.if_pc         = t_if_pc;
    assign bus16.ex_valid      = t_valid;
    assign bus16.ex_branch     = t_branch;
    assign bus16.ex_pc         = t_ex_pc;
    assign bus16.ex_cond       = t_cond;
    assign bus16.ex_flags      = t_flags;
    assign bus16.ex_pred_taken = t_pred;
    assign bus4.if_pc          = t_if_pc;
    assign bus4.ex_valid       = t_valid;
    assign bus4.ex_branch      = t_branch;
    assign bus4.ex_pc          = t_ex_pc;
    assign bus4.ex_cond        = t_cond;
    assign bus4.ex_flags       = t_flags;
    assign bus4.ex_pred_taken  = t_pred;

    branch_predict_unit #(
        .PC_WIDTH(PW), .BHT_DEPTH(DEPTH), .CNT_WIDTH(16)
    ) dut (
        .clk(clk), .reset(reset), .bpu(bus16.slave)
    );

    branch_predict_unit #(
        .PC_WIDTH(PW), .BHT_DEPTH(DEPTH), .CNT_WIDTH(4)
    ) dut4 (
        .clk(clk), .reset(reset), .bpu(bus4.slave)
    );

    int n_chk  = 0;
    int n_fail = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs,
                            input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Behavioural model
    int m_bht [DEPTH];
    int m_rv, m_rt, m_mp;
    int m_bc, m_mc, m_bc4, m_mc4;
    bit m_init = 0;

    function automatic int idx_of(input logic [31:0] pc);
        return int'((pc >> 2) % DEPTH);
    endfunction

    function automatic bit ref_cond(input int c, input logic [3:0] f);
        bit n, z, cf, v;
        n = f[3]; z = f[2]; cf = f[1]; v = f[0];
        case (c)
            0:  return z;
            1:  return !z;
            2:  return cf;
            3:  return !cf;
            4:  return n;
            5:  return !n;
            6:  return v;
            7:  return !v;
            8:  return cf && !z;
            9:  return !cf || z;
            10: return n == v;
            11: return n != v;
            12: return !z && (n == v);
            13: return z || (n != v);
            14: return 1;
            default: return 0;
        endcase
    endfunction

    task automatic model_edge();
        bit r, tk, miss;
        int k;
        if (reset) begin
            foreach (m_bht[i]) m_bht[i] = 1;
            m_rv = 0; m_rt = 0; m_mp = 0;
            m_bc = 0; m_mc = 0; m_bc4 = 0; m_mc4 = 0;
            m_init = 1;
        end else begin
            r    = t_valid && t_branch;
            tk   = ref_cond(int'(t_cond), t_flags);
            miss = (tk != t_pred);
            m_rv = r;
            m_rt = r && tk;
            m_mp = r && miss;
            if (r) begin
                k = idx_of(t_ex_pc);
                if (tk) m_bht[k] = (m_bht[k] < 3) ? m_bht[k] + 1 : 3;
                else    m_bht[k] = (m_bht[k] > 0) ? m_bht[k] - 1 : 0;
                if (m_bc < 65535) m_bc++;
                if (m_bc4 < 15) m_bc4++;
                if (miss) begin
                    if (m_mc < 65535) m_mc++;
                    if (m_mc4 < 15) m_mc4++;
                end
            end
        end
    endtask

    // Entered 1 time unit after a rising edge with inputs already set.
    task automatic drive_cycle();
        #3;
        if (m_init) begin
            check_eq("pred16", bus16.if_pred_taken,
                     m_bht[idx_of(t_if_pc)] >= 2);
            check_eq("pred4", bus4.if_pred_taken,
                     m_bht[idx_of(t_if_pc)] >= 2);
        end
        @(posedge clk);
        model_edge();
        #1;
        check_eq("res_valid", bus16.res_valid, m_rv);
        check_eq("res_taken", bus16.res_taken, m_rt);
        check_eq("mispredict", bus16.mispredict, m_mp);
        check_eq("branch_count", bus16.branch_count, m_bc);
        check_eq("mispred_count", bus16.mispred_count, m_mc);
        check_eq("branch_count4", bus4.branch_count, m_bc4);
        check_eq("mispred_count4", bus4.mispred_count, m_mc4);
    endtask

    task automatic idle_inputs();
        t_valid = 0; t_branch = 0; t_cond = 4'hE;
        t_flags = 0; t_pred = 0; t_ex_pc = 0; t_if_pc = 0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1;
        drive_cycle();
        reset = 0;
    endtask

    initial begin
        reset = 1;
        idle_inputs();
        #1;
        drive_cycle();
        reset = 0;

        // Reset state of every entry
        for (int pc = 0; pc <= 'hFC; pc += 4) begin
            t_if_pc = pc;
            drive_cycle();
        end

        // BEQ taken three times at 0x40, predicted not-taken each time
        do_reset();
        t_valid = 1; t_branch = 1; t_ex_pc = 32'h40;
        t_cond = 4'h0; t_flags = 4'b0100; t_pred = 0;
        for (int i = 0; i < 3; i++) begin
            drive_cycle();
            check_eq("t2_mispredict", bus16.mispredict, 1);
        end
        t_valid = 0; t_if_pc = 32'h40;
        drive_cycle();
        check_eq("t2_pred", bus16.if_pred_taken, 1);
        check_eq("t2_count", bus16.mispred_count, 3);

        // Full condition x flag table
        for (int c = 0; c < 16; c++) begin
            for (int f = 0; f < 16; f++) begin
                t_valid = 1; t_branch = 1; t_pred = 0;
                t_cond = 4'(c); t_flags = 4'(f);
                t_ex_pc = $urandom; t_if_pc = $urandom;
                drive_cycle();
                if (c == 15)
                    check_eq("nv_taken", bus16.res_taken, 0);
            end
        end

        // Read-before-write on the same index
        do_reset();
        t_if_pc = 32'h80; t_ex_pc = 32'h80;
        t_valid = 1; t_branch = 1; t_cond = 4'hE; t_pred = 0;
        #2;
        check_eq("t4_same", bus16.if_pred_taken, 0);
        drive_cycle();
        t_valid = 0;
        #2;
        check_eq("t4_next", bus16.if_pred_taken, 1);
        drive_cycle();

        // Squashed branches then stats saturation on the narrow copy
        do_reset();
        for (int i = 0; i < 20; i++) begin
            t_valid = 0; t_branch = 1; t_cond = 4'hE;
            t_ex_pc = 32'h80; t_if_pc = 32'h80;
            drive_cycle();
        end
        check_eq("t5_squash_cnt", bus16.branch_count, 0);
        check_eq("t5_squash_pred", bus16.if_pred_taken, 0);
        for (int i = 0; i < 20; i++) begin
            t_valid = 1; t_branch = 1; t_cond = 4'($urandom);
            t_flags = 4'($urandom); t_pred = 1'($urandom);
            t_ex_pc = $urandom; t_if_pc = $urandom;
            drive_cycle();
        end
        check_eq("t5_sat4", bus4.branch_count, 15);
        check_eq("t5_cnt16", bus16.branch_count, 20);

        // Reset wins over a same-cycle resolve
        do_reset();
        t_valid = 1; t_branch = 1; t_cond = 4'hE; t_pred = 0;
        t_ex_pc = 32'h80; t_if_pc = 32'h80;
        for (int i = 0; i < 3; i++) drive_cycle();
        reset = 1;
        drive_cycle();
        check_eq("t6_res_valid", bus16.res_valid, 0);
        reset = 0; t_valid = 0;
        #2;
        check_eq("t6_pred", bus16.if_pred_taken, 0);
        drive_cycle();

        // Random traffic with aliasing PCs and occasional reset
        for (int i = 0; i < 3000; i++) begin
            int sel;
            sel = int'($urandom_range(0, 3));
            case (sel)
                0: t_ex_pc = 32'h40;
                1: t_ex_pc = 32'h140;
                2: t_ex_pc = 32'h1040;
                default: t_ex_pc = $urandom;
            endcase
            t_if_pc  = ($urandom_range(0, 1) == 1) ? t_ex_pc : $urandom;
            t_valid  = ($urandom_range(0, 7) != 0);
            t_branch = ($urandom_range(0, 7) != 0);
            t_cond   = 4'($urandom);
            t_flags  = 4'($urandom);
            t_pred   = 1'($urandom);
            reset    = ($urandom_range(0, 199) == 0);
            drive_cycle();
        end
        reset = 0;

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
